// File: rtl/conv8_32.sv
// conv8_32: byte-to-word assembler.
// Packs each run of four consecutive valid bytes into one 32-bit word and
// emits it with a one-cycle strobe. A gap in the byte stream mid-word drops
// the partial word and pulses err_frag once.
module conv8_32 #(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic        clk_4f,
    input  logic        reset,
    input  logic [7:0]  in_data8,
    input  logic        in8,
    output logic [31:0] out_data32,
    output logic        out32,
    output logic        err_frag
);

    // Byte slots held for the current word. Slot k holds byte k of the word.
    logic [1:0]      cnt;
    logic [2:0][7:0] acc;

    // The four bytes of the word being completed, indexed by arrival order.
    logic [3:0][7:0] word_bytes;
    logic [31:0]     word;

    assign word_bytes = {in_data8, acc[2], acc[1], acc[0]};

    // Place byte k either from the top down or from the bottom up.
    for (genvar k = 0; k < 4; k++) begin : g_place
        if (MSB_FIRST) begin : g_msb
            assign word[31-8*k -: 8] = word_bytes[k];
        end else begin : g_lsb
            assign word[8*k +: 8] = word_bytes[k];
        end
    end

    // Byte collection, word completion and fragment detection.
    // acc is not cleared on a discard: it is never read while cnt is 0.
    always_ff @(posedge clk_4f) begin
        if (reset) begin
            cnt        <= 2'd0;
            acc        <= '0;
            out_data32 <= '0;
            out32      <= 1'b0;
            err_frag   <= 1'b0;
        end else if (in8) begin
            err_frag <= 1'b0;
            if (cnt == 2'd3) begin
                out_data32 <= word;
                out32      <= 1'b1;
                cnt        <= 2'd0;
            end else begin
                acc[cnt] <= in_data8;
                out32    <= 1'b0;
                cnt      <= cnt + 2'd1;
            end
        end else begin
            out32    <= 1'b0;
            err_frag <= (cnt != 2'd0);
            cnt      <= 2'd0;
        end
    end

endmodule

// File: tb/tb_conv8_32.sv
// tb_conv8_32: directed test-plan sequences plus randomized byte streams,
// checked every cycle against a queue-based reference model. Two instances
// cover both byte orders from the same stimulus.
module tb_conv8_32;

    logic        clk_4f = 1'b0;
    logic        reset;
    logic [7:0]  in_data8;
    logic        in8;
    logic [31:0] out_data32_m, out_data32_l;
    logic        out32_m, out32_l, err_frag_m, err_frag_l;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [7:0]  q[$];
    logic [31:0] exp_m, exp_l;
    logic        exp_v, exp_e;

    always #5 clk_4f = ~clk_4f;

    conv8_32 #(.MSB_FIRST(1'b1)) u_msb (
        .clk_4f(clk_4f), .reset(reset), .in_data8(in_data8), .in8(in8),
        .out_data32(out_data32_m), .out32(out32_m), .err_frag(err_frag_m)
    );

    conv8_32 #(.MSB_FIRST(1'b0)) u_lsb (
        .clk_4f(clk_4f), .reset(reset), .in_data8(in_data8), .in8(in8),
        .out_data32(out_data32_l), .out32(out32_l), .err_frag(err_frag_l)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle, advance the model, then check both instances.
    task automatic step(input logic r, input logic v, input logic [7:0] d);
        reset    = r;
        in8      = v;
        in_data8 = d;
        @(posedge clk_4f);
        if (r) begin
            q.delete();
            exp_m = '0; exp_l = '0; exp_v = 1'b0; exp_e = 1'b0;
        end else if (v) begin
            exp_e = 1'b0;
            q.push_back(d);
            if (q.size() == 4) begin
                exp_m = (32'(q[0]) << 24) | (32'(q[1]) << 16) | (32'(q[2]) << 8) | 32'(q[3]);
                exp_l = (32'(q[3]) << 24) | (32'(q[2]) << 16) | (32'(q[1]) << 8) | 32'(q[0]);
                exp_v = 1'b1;
                q.delete();
            end else begin
                exp_v = 1'b0;
            end
        end else begin
            exp_v = 1'b0;
            exp_e = (q.size() != 0);
            q.delete();
        end
        #1;
        chk("data_msb", out_data32_m, exp_m);
        chk("data_lsb", out_data32_l, exp_l);
        chk("out32_msb", {31'd0, out32_m}, {31'd0, exp_v});
        chk("out32_lsb", {31'd0, out32_l}, {31'd0, exp_v});
        chk("err_msb", {31'd0, err_frag_m}, {31'd0, exp_e});
        chk("err_lsb", {31'd0, err_frag_l}, {31'd0, exp_e});
    endtask

    task automatic send(input logic [7:0] d);
        step(1'b0, 1'b1, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        exp_m = '0; exp_l = '0; exp_v = 1'b0; exp_e = 1'b0;
        reset = 1'b1; in8 = 1'b1; in_data8 = 8'hFF;

        // Reset with valid bytes present: nothing emitted.
        step(1'b1, 1'b1, 8'hFF);
        step(1'b1, 1'b1, 8'hFF);
        chk("reset_data", out_data32_m, 32'h0);
        idle(1);

        // Single word, then a gap at a word boundary.
        send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
        chk("single_msb", out_data32_m, 32'hAABBCCDD);
        chk("single_lsb", out_data32_l, 32'hDDCCBBAA);
        idle(3);
        chk("single_hold", out_data32_m, 32'hAABBCCDD);

        // Back-to-back words.
        for (int i = 1; i <= 8; i++) begin
            send(8'(i));
            if (i == 4) chk("b2b_w0", out_data32_m, 32'h01020304);
        end
        chk("b2b_w1", out_data32_m, 32'h05060708);
        idle(1);

        // Fragment followed by a multi-cycle gap.
        send(8'h11); send(8'h22);
        idle(3);
        send(8'h33); send(8'h44); send(8'h55); send(8'h66);
        chk("frag_next", out_data32_m, 32'h33445566);

        // Reset mid-word.
        send(8'h9A); send(8'hBC);
        step(1'b1, 1'b1, 8'h77);
        chk("rst_mid_data", out_data32_m, 32'h0);
        chk("rst_mid_err", {31'd0, err_frag_m}, 32'h0);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        chk("rst_mid_next", out_data32_m, 32'h01020304);

        // Randomized streams with gaps and occasional resets.
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 99) < 80), 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
